weight_bias_loader: RTL and testbench

Streams trained weights and biases from a single word stream (AXI-stream/DMA side) into a layer of neurons through the neurons' configuration interface. It assigns each incoming word to a layer/neuron index, drives the weight write strobe and the bias strobe, and holds the target index stable while that neuron is loaded. It sits between the AXI input FIFO and one layer of neurons, and is the transmitting end of the neurons' weight/bias load port.

---
 rtl/weight_bias_loader.sv | 153 +++++++++++++++
 tb/tb_weight_bias_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/weight_bias_loader.sv
// weight_bias_loader: walks a single weight/bias word stream into one layer of
// neurons. Each neuron receives numWeight weights followed by one bias. The
// target layer/neuron index is held stable while that neuron is loaded.
module weight_bias_loader #(
  parameter int dataWidth   = 16,
  parameter int numWeight   = 128,
  parameter int numNeurons  = 64,
  parameter int layerNo     = 1,
  parameter int firstNeuron = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [dataWidth-1:0]   s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   weightValid,
  output logic [dataWidth-1:0]   weightValue,
  output logic                   biasValid,
  output logic [dataWidth-1:0]   biasValue,
  output logic [2*dataWidth:0]   config_layer_num,
  output logic [2*dataWidth:0]   config_neuron_num,
  output logic                   busy,
  output logic                   done
);

  localparam int WCW  = $clog2(numWeight + 1);
  localparam int NCW  = $clog2(numNeurons + 1);
  localparam int CFGW = 2 * dataWidth + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WEIGHTS,
    S_BIAS,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WCW-1:0]     r_wcnt;
  logic [NCW-1:0]     r_ncnt;
  logic [CFGW-1:0]    r_cfg_layer;
  logic [CFGW-1:0]    r_cfg_neuron;
  logic               r_weight_valid;
  logic               r_bias_valid;
  logic [dataWidth-1:0] r_weight_value;
  logic [dataWidth-1:0] r_bias_value;
  logic               r_done;
  logic               w_ready;
  logic               w_busy;
  logic               w_xfer;
  logic               w_last_weight;
  logic               w_last_neuron;

  assign w_last_weight = (r_wcnt == WCW'(numWeight - 1));
  assign w_last_neuron = (r_ncnt == NCW'(numNeurons - 1));
  assign w_xfer        = s_valid & w_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and stream handshake; next state uses s_valid directly so the
  // ready output never feeds back into its own decode
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_WEIGHTS;
      end
      S_WEIGHTS: begin
        w_ready = 1'b1;
        if (s_valid && w_last_weight) w_next = S_BIAS;
      end
      S_BIAS: begin
        w_ready = 1'b1;
        if (s_valid) w_next = w_last_neuron ? S_DONE : S_NEXT;
      end
      S_NEXT: begin
        w_next = S_WEIGHTS;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Counters and target index; the neuron index only moves in the NEXT gap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt       <= '0;
      r_ncnt       <= '0;
      r_cfg_layer  <= '0;
      r_cfg_neuron <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cfg_layer  <= CFGW'(layerNo);
            r_cfg_neuron <= CFGW'(firstNeuron);
            r_wcnt       <= '0;
            r_ncnt       <= '0;
          end
        end
        S_WEIGHTS: begin
          if (s_valid) r_wcnt <= r_wcnt + WCW'(1);
        end
        S_NEXT: begin
          r_cfg_neuron <= r_cfg_neuron + CFGW'(1);
          r_ncnt       <= r_ncnt + NCW'(1);
          r_wcnt       <= '0;
        end
        default: ;
      endcase
    end
  end

  // Registered strobes and data words, plus the completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_weight_valid <= 1'b0;
      r_bias_valid   <= 1'b0;
      r_weight_value <= '0;
      r_bias_value   <= '0;
      r_done         <= 1'b0;
    end else begin
      r_weight_valid <= w_xfer && (r_state == S_WEIGHTS);
      r_bias_valid   <= w_xfer && (r_state == S_BIAS);
      if (w_xfer && (r_state == S_WEIGHTS)) r_weight_value <= s_data;
      if (w_xfer && (r_state == S_BIAS))    r_bias_value   <= s_data;
      r_done <= (r_state == S_DONE);
    end
  end

  assign s_ready           = w_ready;
  assign busy              = w_busy;
  assign weightValid       = r_weight_valid;
  assign weightValue       = r_weight_value;
  assign biasValid         = r_bias_valid;
  assign biasValue         = r_bias_value;
  assign config_layer_num  = r_cfg_layer;
  assign config_neuron_num = r_cfg_neuron;
  assign done              = r_done;

endmodule

// File: tb/tb_weight_bias_loader.sv
// Bench for weight_bias_loader: 4 weights x 3 neurons starting at neuron 5.
// A cycle-level reference model derived from the stream rules predicts every
// output each cycle; stimulus mixes directed and $urandom valid/data patterns.
module tb_weight_bias_loader;

  localparam int DW    = 16;
  localparam int NW    = 4;
  localparam int NN    = 3;
  localparam int LAYER = 1;
  localparam int FIRST = 5;
  localparam int TOTAL = NN * (NW + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;
  logic            weightValid;
  logic [DW-1:0]   weightValue;
  logic            biasValid;
  logic [DW-1:0]   biasValue;
  logic [2*DW:0]   config_layer_num;
  logic [2*DW:0]   config_neuron_num;
  logic            busy;
  logic            done;

  weight_bias_loader #(
    .dataWidth  (DW),
    .numWeight  (NW),
    .numNeurons (NN),
    .layerNo    (LAYER),
    .firstNeuron(FIRST)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .weightValid      (weightValid),
    .weightValue      (weightValue),
    .biasValid        (biasValid),
    .biasValue        (biasValue),
    .config_layer_num (config_layer_num),
    .config_neuron_num(config_neuron_num),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: expectations for the current cycle
  bit            chk_en    = 1'b0;
  logic          e_ready   = 1'b0;
  logic          e_busy    = 1'b0;
  logic          e_done    = 1'b0;
  logic          e_wv      = 1'b0;
  logic          e_bv      = 1'b0;
  logic [DW-1:0] e_wval    = '0;
  logic [DW-1:0] e_bval    = '0;
  int            e_layer   = 0;
  int            e_neuron  = 0;
  bit            m_active  = 1'b0;
  bit            m_gap     = 1'b0;
  int            m_donecnt = 0;
  int            xcount    = 0;

  logic [DW-1:0] words [TOTAL];

  // Check every output against the model, then advance the model one cycle
  always @(negedge clk) begin
    bit xfer, isb, last, new_gap;
    if (chk_en) begin
      check_val("s_ready",     64'(s_ready),           64'(e_ready));
      check_val("busy",        64'(busy),              64'(e_busy));
      check_val("done",        64'(done),              64'(e_done));
      check_val("weightValid", 64'(weightValid),       64'(e_wv));
      check_val("biasValid",   64'(biasValid),         64'(e_bv));
      check_val("weightValue", 64'(weightValue),       64'(e_wval));
      check_val("biasValue",   64'(biasValue),         64'(e_bval));
      check_val("layer_num",   64'(config_layer_num),  64'(e_layer));
      check_val("neuron_num",  64'(config_neuron_num), 64'(e_neuron));
      if (rst) begin
        e_ready = 0; e_busy = 0; e_done = 0; e_wv = 0; e_bv = 0;
        e_wval = '0; e_bval = '0; e_layer = 0; e_neuron = 0;
        m_active = 0; m_gap = 0; m_donecnt = 0; xcount = 0;
      end else begin
        xfer    = s_valid && e_ready;
        isb     = (xcount % (NW + 1)) == NW;
        last    = (xcount == TOTAL - 1);
        e_wv    = xfer && !isb;
        e_bv    = xfer && isb;
        if (e_wv) e_wval = s_data;
        if (e_bv) e_bval = s_data;
        if (m_gap) e_neuron = e_neuron + 1;
        new_gap = xfer && isb && !last;
        if (m_donecnt > 0) m_donecnt = m_donecnt - 1;
        if (start && !e_busy) begin
          m_active = 1; xcount = 0; e_layer = LAYER; e_neuron = FIRST;
        end
        if (xfer) begin
          xcount = xcount + 1;
          if (last) begin
            m_active  = 0;
            m_donecnt = 2;
          end
        end
        e_busy  = m_active || (m_donecnt == 2);
        e_done  = (m_donecnt == 1);
        e_ready = m_active && !new_gap;
        m_gap   = new_gap;
      end
    end
  end

  task automatic fill(input bit rnd);
    for (int i = 0; i < TOTAL; i++)
      words[i] = rnd ? DW'($urandom) : DW'(i + 1);
  endtask

  // mode 0: valid held high, 1: valid every other cycle, 2: random valid
  task automatic do_load(input int mode, input int restart_at, input int rst_at, input int idle_pre);
    bit restarted = 1'b0;
    bit aborted   = 1'b0;
    start   = 1'b1;
    s_valid = 1'b0;
    s_data  = words[0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (xcount == TOTAL && !e_busy) break;
      if (c < idle_pre)   s_valid = 1'b0;
      else if (mode == 0) s_valid = 1'b1;
      else if (mode == 1) s_valid = (c % 2 == 0);
      else                s_valid = ($urandom_range(0, 1) == 1);
      s_data = (xcount < TOTAL) ? words[xcount] : '0;
      start  = 1'b0;
      if (restart_at >= 0 && !restarted && xcount == restart_at) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      if (rst_at >= 0 && xcount == rst_at) begin
        rst     = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
      if (aborted) begin
        rst = 1'b0;
        break;
      end
    end
    start   = 1'b0;
    s_valid = 1'b0;
    if (!aborted) check_val("load_words", 64'(xcount), 64'(TOTAL));
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    fill(1'b0);
    do_load(0, -1, -1, 0);   // words 1..15, valid held high
    do_load(1, -1, -1, 0);   // valid toggling
    do_load(0, 6, -1, 0);    // start again during neuron 6 weights
    do_load(0, -1, 7, 0);    // reset after word 7
    do_load(0, -1, -1, 0);   // fresh load after reset

    fill(1'b1);
    do_load(2, -1, -1, 20);  // 20-cycle stall right after start
    repeat (4) begin
      fill(1'b1);
      do_load(2, -1, -1, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
